// File: rtl/axis_s.sv
// AXI-Stream receiver: accepts 32-bit beats into a first-word-fall-through FIFO,
// counts beats per packet and reports packet completion and length errors.
module axis_s #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int PKT_LEN = 40
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              en,
  input  logic              tvalid,
  output logic              tready,
  input  logic [DATA_W-1:0] tdata,
  input  logic              tlast,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              pkt_done,
  output logic [15:0]       pkt_len,
  output logic              len_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [15:0]   EXP_LEN = 16'(PKT_LEN);

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state, state_nxt;
  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   occ;
  logic [15:0]     beat_cnt, beat_inc;
  logic            push, pop;

  always_comb begin
    beat_inc  = (beat_cnt == '1) ? beat_cnt : beat_cnt + 16'd1;
    busy      = (state == RECV);
    tready    = busy && (occ < FULL);
    out_valid = (occ != '0);
    out_data  = mem[rd_ptr][DATA_W-1:0];
    out_last  = out_valid & mem[rd_ptr][DATA_W];
    push      = tvalid & tready;
    pop       = out_valid & out_ready;
  end

  // en only matters while idle or on the accepted tlast beat
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RECV;
      RECV:    if (push && tlast && !en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      beat_cnt <= '0;
      pkt_done <= 1'b0;
      len_err  <= 1'b0;
      pkt_len  <= '0;
    end else begin
      state    <= state_nxt;
      pkt_done <= 1'b0;
      len_err  <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (tlast) begin
          pkt_len  <= beat_inc;
          pkt_done <= 1'b1;
          len_err  <= (PKT_LEN != 0) && (beat_inc != EXP_LEN);
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_inc;
        end
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {tlast, tdata};
  end

endmodule

// File: tb/tb_axis_s.sv
// Bench for axis_s: queue-based reference model checked every cycle, plus
// directed packet scenarios with hand-computed expectations.
module tb_axis_s;
  localparam int DW      = 32;
  localparam int DEPTH   = 8;
  localparam int PKT_LEN = 40;

  logic          aclk = 1'b0, rst = 1'b1, en = 1'b0, tvalid = 1'b0, tlast = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [DW-1:0] out_data;
  logic          tready, out_last, out_valid, busy, pkt_done, len_err;
  logic [15:0]   pkt_len;

  always #5 aclk = ~aclk;

  axis_s #(.DATA_W(DW), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
    .aclk(aclk), .rst(rst), .en(en), .tvalid(tvalid), .tready(tready),
    .tdata(tdata), .tlast(tlast), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .pkt_done(pkt_done), .pkt_len(pkt_len), .len_err(len_err)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {last,data}, a receiving flag and a beat count
  logic [DW:0] mq[$];
  bit          m_recv, m_done, m_err, model_on = 0;
  logic [15:0] m_cnt, m_plen;

  always @(posedge aclk) begin : model
    bit was_recv, acc;
    logic [15:0] n;
    if (rst) begin
      mq.delete();
      m_recv = 0; m_done = 0; m_err = 0; m_cnt = '0; m_plen = '0;
      model_on = 1;
    end else begin
      was_recv = m_recv;
      acc = tvalid && was_recv && (mq.size() < DEPTH);
      m_done = 0; m_err = 0;
      if (out_ready && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({tlast, tdata});
        n = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        if (tlast) begin
          m_plen = n; m_done = 1; m_err = (PKT_LEN != 0) && (n != PKT_LEN);
          m_cnt = '0;
          if (!en) m_recv = 0;
        end else begin
          m_cnt = n;
        end
      end
      if (!was_recv && en) m_recv = 1;
    end
  end

  int n_acc = 0, n_done = 0, n_err = 0;
  logic [DW:0] popq[$];

  always @(negedge aclk) begin
    if (model_on) begin
      chk("tready", tready, m_recv && (mq.size() < DEPTH));
      chk("busy", busy, m_recv);
      chk("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("out_data", out_data, mq[0][DW-1:0]);
        chk("out_last", out_last, mq[0][DW]);
      end else begin
        chk("out_last", out_last, 0);
      end
      chk("pkt_done", pkt_done, m_done);
      chk("len_err", len_err, m_err);
      chk("pkt_len", pkt_len, m_plen);
      if (tvalid && tready) n_acc++;
      if (out_valid && out_ready) popq.push_back({out_last, out_data});
      if (pkt_done) begin
        n_done++;
        if (len_err) n_err++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit last, output int waits);
    bit r;
    waits = 0; tvalid = 1'b1; tdata = d; tlast = last;
    forever begin
      @(negedge aclk); r = tready;
      @(posedge aclk); #1;
      if (r) break;
      waits++;
      if (waits > 100) begin
        chk("beat_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic send_pkt(input logic [DW-1:0] d, input int n, input bit incr,
                          input bit gap, output int waits_total);
    int w;
    waits_total = 0;
    for (int i = 0; i < n; i++) begin
      beat(incr ? d + DW'(i) : d, i == n - 1, w);
      waits_total += w;
      if (gap) begin
        tvalid = 1'b0; tlast = 1'b0; tick();
      end
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  initial begin
    int w, w2, d0, e0, a0, bad, lasts, last_idx;
    bit r;

    rst = 1'b1; tick(4);
    chk("rst_tready", tready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_done", pkt_done, 0);
    chk("rst_pkt_len", pkt_len, 0);
    rst = 1'b0;

    // single 40-beat packet, en dropped after entry
    en = 1'b1; out_ready = 1'b1; tick();
    chk("t1_busy_after_en", busy, 1);
    chk("t1_tready_after_en", tready, 1);
    en = 1'b0; popq.delete(); d0 = n_done; e0 = n_err;
    send_pkt(32'hAAAABBBB, 40, 0, 0, w);
    tick(3);
    chk("t1_stalls", w, 0);
    chk("t1_done", n_done - d0, 1);
    chk("t1_err", n_err - e0, 0);
    chk("t1_pkt_len", pkt_len, 40);
    chk("t1_busy_end", busy, 0);
    chk("t1_pops", popq.size(), 40);
    bad = 0; lasts = 0; last_idx = -1;
    foreach (popq[i]) begin
      if (popq[i][DW-1:0] !== 32'hAAAABBBB) bad++;
      if (popq[i][DW]) begin lasts++; last_idx = i; end
    end
    chk("t1_data", bad, 0);
    chk("t1_last_count", lasts, 1);
    chk("t1_last_idx", last_idx, 39);

    // backpressure: fill FIFO, then one pop frees one slot
    out_ready = 1'b0; en = 1'b1; tick();
    a0 = n_acc;
    tvalid = 1'b1; tlast = 1'b0; tdata = 32'h0000_1000;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk); r = tready;
      @(posedge aclk); #1;
      if (r) tdata = tdata + 32'd1;
    end
    chk("t2_accepts_full", n_acc - a0, 8);
    chk("t2_tready_full", tready, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t2_tready_after_pop", tready, 1);
    tick();
    chk("t2_tready_refull", tready, 0);
    tick(3);
    chk("t2_accepts_total", n_acc - a0, 9);
    tvalid = 1'b0; out_ready = 1'b1; tick(12);
    d0 = n_done; e0 = n_err;
    beat(32'h0000_2000, 1, w); tvalid = 1'b0; tlast = 1'b0;
    tick(2);
    chk("t2_pkt_len", pkt_len, 10);
    chk("t2_err", n_err - e0, 1);

    // short packet: length error
    d0 = n_done; e0 = n_err;
    send_pkt(32'h5555_0000, 5, 1, 0, w);
    tick(2);
    chk("t3_done", n_done - d0, 1);
    chk("t3_err", n_err - e0, 1);
    chk("t3_pkt_len", pkt_len, 5);

    // back-to-back packets A then B
    tick(2); popq.delete(); d0 = n_done; e0 = n_err;
    send_pkt(32'hAAAABBBB, 40, 0, 0, w);
    send_pkt(32'hCCCCDDDD, 40, 0, 0, w2);
    tick(4);
    chk("t4_stalls", w + w2, 0);
    chk("t4_done", n_done - d0, 2);
    chk("t4_err", n_err - e0, 0);
    chk("t4_pops", popq.size(), 80);
    bad = 0;
    foreach (popq[i])
      if (popq[i][DW-1:0] !== ((i < 40) ? 32'hAAAABBBB : 32'hCCCCDDDD)) bad++;
    chk("t4_order", bad, 0);

    // reset mid-packet with 3 beats buffered
    out_ready = 1'b0; d0 = n_done;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) out_ready = 1'b1;
      beat(32'h7000_0000 + 32'(i), 0, w);
    end
    rst = 1'b1; tvalid = 1'b0; out_ready = 1'b0; tick();
    chk("t5_out_valid", out_valid, 0);
    chk("t5_tready", tready, 0);
    chk("t5_busy", busy, 0);
    rst = 1'b0; tick(2);
    chk("t5_no_done", n_done - d0, 0);
    en = 1'b1; out_ready = 1'b1; tick();
    send_pkt(32'h8000_0000, 40, 1, 0, w);
    tick(2);
    chk("t5_pkt_len", pkt_len, 40);
    chk("t5_done", n_done - d0, 1);

    // tvalid toggling every cycle
    tick(2); popq.delete();
    send_pkt(32'h6000_0000, 40, 1, 1, w);
    tick(4);
    chk("t6_pkt_len", pkt_len, 40);
    chk("t6_pops", popq.size(), 40);
    bad = 0;
    foreach (popq[i]) if (popq[i][DW-1:0] !== 32'h6000_0000 + 32'(i)) bad++;
    chk("t6_order", bad, 0);

    en = 1'b0; tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
